psum_buffer: RTL and testbench



---
 rtl/psum_buffer.sv | 112 +++++++++++
 tb/tb_psum_buffer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/psum_buffer.sv
// psum_buffer: one circular FIFO bank per PE column, holding partial sums
// between the bottom row (writes, MODE1) and the top row (reads, MODE2)
// of the PE array. Handshakes are combinational from state and inputs.
module psum_buffer #(
  parameter int COLS   = 7,
  parameter int DEPTH  = 16,
  parameter int DATA_W = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [1:0]                    mode_in,
  input  logic                          change_mode,
  input  logic                          flush,
  input  logic [COLS-1:0]               wr_valid,
  input  logic [COLS-1:0][DATA_W-1:0]   wr_data,
  output logic [COLS-1:0]               wr_ack,
  output logic [COLS-1:0]               rd_valid,
  output logic [COLS-1:0][DATA_W-1:0]   rd_data,
  input  logic [COLS-1:0]               rd_ack,
  output logic [COLS-1:0]               col_empty,
  output logic [COLS-1:0]               col_full,
  output logic                          all_empty,
  output logic                          error
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [1:0] MODE1 = 2'd0;
  localparam logic [1:0] MODE2 = 2'd1;
  localparam logic [1:0] MODE3 = 2'd2;
  localparam logic [1:0] MODE4 = 2'd3;

  logic [1:0]                cur_mode_q, cur_mode_d;
  logic [COLS-1:0][AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [COLS-1:0][AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [COLS-1:0][AW:0]     count_q, count_d;
  logic                      error_q, error_d;
  logic [COLS-1:0]           push, pop;
  logic                      write_en, read_en, bad_mode;

  // Sample storage; no reset since stale entries are never exposed.
  logic [DATA_W-1:0] mem [COLS][DEPTH];

  // Handshakes, status flags and next-state for every bank.
  always_comb begin
    write_en  = (cur_mode_q == MODE1);
    read_en   = (cur_mode_q == MODE2);
    bad_mode  = (cur_mode_q == MODE3) || (cur_mode_q == MODE4);
    cur_mode_d = change_mode ? mode_in : cur_mode_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    wr_ack    = '0;
    rd_valid  = '0;
    rd_data   = '0;
    push      = '0;
    pop       = '0;
    col_empty = '0;
    col_full  = '0;
    for (int j = 0; j < COLS; j++) begin
      col_empty[j] = (count_q[j] == '0);
      col_full[j]  = (count_q[j] == FULL_CNT);
      wr_ack[j]    = wr_valid[j] & write_en & ~col_full[j] & ~flush;
      rd_valid[j]  = read_en & ~col_empty[j] & ~flush;
      rd_data[j]   = rd_valid[j] ? mem[j][rd_ptr_q[j]] : '0;
      push[j]      = wr_ack[j];
      pop[j]       = rd_valid[j] & rd_ack[j];
      if (push[j]) wr_ptr_d[j] = wr_ptr_q[j] + AW'(1);
      if (pop[j])  rd_ptr_d[j] = rd_ptr_q[j] + AW'(1);
      case ({push[j], pop[j]})
        2'b10:   count_d[j] = count_q[j] + (AW+1)'(1);
        2'b01:   count_d[j] = count_q[j] - (AW+1)'(1);
        default: count_d[j] = count_q[j];
      endcase
      // Flush wins over any push/pop in the same cycle.
      if (flush) begin
        wr_ptr_d[j] = '0;
        rd_ptr_d[j] = '0;
        count_d[j]  = '0;
      end
    end
    all_empty = &col_empty;
    error_d   = error_q | (|(rd_ack & ~rd_valid)) | ((|wr_valid) & bad_mode);
    error     = error_q;
  end

  // Control state: mode, pointers, counts and the sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_mode_q <= MODE1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      error_q    <= 1'b0;
    end else begin
      cur_mode_q <= cur_mode_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      error_q    <= error_d;
    end
  end

  // Bank writes; a write coinciding with reset is discarded.
  always_ff @(posedge clk) begin
    for (int j = 0; j < COLS; j++) begin
      if (push[j] && !rst) mem[j][wr_ptr_q[j]] <= wr_data[j];
    end
  end

endmodule

// File: tb/tb_psum_buffer.sv
// tb_psum_buffer: scenario tasks driving psum_buffer, with a queue
// scoreboard holding the expected read order of the column under test.
module tb_psum_buffer;

  localparam int COLS = 7;
  localparam int DW   = 16;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [1:0]             mode_in;
  logic                   change_mode;
  logic                   flush;
  logic [COLS-1:0]        wr_valid;
  logic [COLS-1:0][DW-1:0] wr_data;
  logic [COLS-1:0]        wr_ack;
  logic [COLS-1:0]        rd_valid;
  logic [COLS-1:0][DW-1:0] rd_data;
  logic [COLS-1:0]        rd_ack;
  logic [COLS-1:0]        col_empty;
  logic [COLS-1:0]        col_full;
  logic                   all_empty;
  logic                   error;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] sb_q [$];
  logic [DW-1:0] exp_v;

  psum_buffer #(.COLS(COLS), .DEPTH(16), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .mode_in(mode_in), .change_mode(change_mode),
    .flush(flush), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ack(wr_ack),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ack(rd_ack),
    .col_empty(col_empty), .col_full(col_full), .all_empty(all_empty),
    .error(error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mode(input logic [1:0] m);
    mode_in = m;
    change_mode = 1'b1;
    tick();
    change_mode = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode_in = 2'd0; change_mode = 1'b0; flush = 1'b0;
    wr_valid = '0; wr_data = '0; rd_ack = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++; if (all_empty !== 1'b1) begin errors++; $display("FAIL reset_all_empty got %b want 1", all_empty); end
    checks++; if (rd_valid !== 7'h00) begin errors++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
    checks++; if (wr_ack !== 7'h00) begin errors++; $display("FAIL reset_wr_ack got %b want 0", wr_ack); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error got %b want 0", error); end
    checks++; if (col_empty !== 7'h7f || col_full !== 7'h00) begin errors++; $display("FAIL reset_flags empty %b full %b want 1111111 0000000", col_empty, col_full); end
    checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
  endtask

  task automatic test_fill_col3();
    for (int i = 1; i <= 16; i++) begin
      wr_valid = 7'b0001000;
      wr_data[3] = DW'(i);
      #1;
      checks++; if (wr_ack !== 7'b0001000) begin errors++; $display("FAIL fill_ack%0d got %b want 0001000", i, wr_ack); end
      sb_q.push_back(DW'(i));
      tick();
    end
    checks++; if (col_full[3] !== 1'b1) begin errors++; $display("FAIL fill_full got %b want 1", col_full[3]); end
    wr_data[3] = 16'h0011;
    #1;
    checks++; if (wr_ack !== 7'h00) begin errors++; $display("FAIL fill_17th_ack got %b want 0", wr_ack); end
    tick();
    wr_valid = '0;
    #1;
    checks++; if (col_empty !== 7'b1110111) begin errors++; $display("FAIL fill_other_empty got %b want 1110111", col_empty); end
    checks++; if (rd_valid !== 7'h00) begin errors++; $display("FAIL fill_no_read_mode1 got %b want 0", rd_valid); end
  endtask

  task automatic test_drain_col3();
    set_mode(2'd1);
    for (int i = 1; i <= 16; i++) begin
      rd_ack = 7'b0001000;
      #1;
      exp_v = sb_q.pop_front();
      checks++; if (rd_valid[3] !== 1'b1 || rd_data[3] !== exp_v) begin errors++; $display("FAIL drain%0d valid %b data %h want 1 %h", i, rd_valid[3], rd_data[3], exp_v); end
      tick();
    end
    rd_ack = '0;
    #1;
    checks++; if (rd_valid[3] !== 1'b0 || col_empty[3] !== 1'b1 || rd_data[3] !== 16'h0) begin errors++; $display("FAIL drain_end valid %b empty %b data %h want 0 1 0000", rd_valid[3], col_empty[3], rd_data[3]); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL drain_error got %b want 0", error); end
  endtask

  // Pushes n values into column 0 in MODE1.
  task automatic push_c0(input int n, input int base);
    set_mode(2'd0);
    for (int i = 0; i < n; i++) begin
      wr_valid = 7'b0000001;
      wr_data[0] = DW'(base + i);
      #1;
      checks++; if (wr_ack[0] !== 1'b1) begin errors++; $display("FAIL wrap_push_ack got %b want 1", wr_ack[0]); end
      sb_q.push_back(DW'(base + i));
      tick();
    end
    wr_valid = '0;
  endtask

  // Pops n values from column 0 in MODE2, comparing against the scoreboard.
  task automatic pop_c0(input int n);
    set_mode(2'd1);
    for (int i = 0; i < n; i++) begin
      rd_ack = 7'b0000001;
      #1;
      exp_v = sb_q.pop_front();
      checks++; if (rd_valid[0] !== 1'b1 || rd_data[0] !== exp_v) begin errors++; $display("FAIL wrap_pop valid %b data %h want 1 %h", rd_valid[0], rd_data[0], exp_v); end
      tick();
    end
    rd_ack = '0;
  endtask

  task automatic test_wrap_col0();
    push_c0(10, 16'h0100);
    pop_c0(10);
    push_c0(4, 16'h0200);
    pop_c0(2);
    push_c0(8, 16'h0204);
    #1;
    checks++; if (col_empty[0] !== 1'b0 || col_full[0] !== 1'b0) begin errors++; $display("FAIL wrap_mid_flags empty %b full %b want 0 0", col_empty[0], col_full[0]); end
    pop_c0(10);
    #1;
    checks++; if (col_empty[0] !== 1'b1 || rd_valid[0] !== 1'b0) begin errors++; $display("FAIL wrap_final_count empty %b valid %b want 1 0", col_empty[0], rd_valid[0]); end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL wrap_scoreboard left %0d want 0", sb_q.size()); end
  endtask

  task automatic test_flush_col5();
    set_mode(2'd0);
    for (int i = 0; i < 7; i++) begin
      wr_valid = 7'b0100000;
      wr_data[5] = DW'(16'h0500 + i);
      tick();
    end
    wr_valid = '0;
    #1;
    checks++; if (col_empty[5] !== 1'b0) begin errors++; $display("FAIL flush_pre_empty got %b want 0", col_empty[5]); end
    flush = 1'b1; wr_valid = 7'b0100000; mode_in = 2'd1; change_mode = 1'b1;
    #1;
    checks++; if (wr_ack !== 7'h00) begin errors++; $display("FAIL flush_wr_ack got %b want 0", wr_ack); end
    tick();
    flush = 1'b0; change_mode = 1'b0;
    #1;
    checks++; if (col_empty[5] !== 1'b1 || all_empty !== 1'b1) begin errors++; $display("FAIL flush_empty col5 %b all %b want 1 1", col_empty[5], all_empty); end
    checks++; if (wr_ack !== 7'h00) begin errors++; $display("FAIL flush_mode_applied wr_ack %b want 0", wr_ack); end
    wr_valid = '0;
    tick();
  endtask

  task automatic test_error();
    #1;
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL err_pre got %b want 0", error); end
    rd_ack = 7'b0000100;
    tick();
    rd_ack = '0;
    tick(); tick();
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL err_rd_ack_sticky got %b want 1", error); end
    rst = 1'b1; tick(); rst = 1'b0; #1;
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL err_cleared got %b want 0", error); end
    set_mode(2'd3);
    wr_valid = 7'b0000010;
    #1;
    checks++; if (wr_ack !== 7'h00) begin errors++; $display("FAIL err_mode4_ack got %b want 0", wr_ack); end
    tick();
    wr_valid = '0;
    #1;
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL err_mode4 got %b want 1", error); end
    rst = 1'b1; tick(); rst = 1'b0;
    wr_valid = 7'b1000000;
    #1;
    checks++; if (wr_ack !== 7'b1000000 || error !== 1'b0) begin errors++; $display("FAIL err_post_reset ack %b err %b want 1000000 0", wr_ack, error); end
    wr_valid = '0;
  endtask

  initial begin
    test_reset();
    test_fill_col3();
    test_drain_col3();
    test_wrap_col0();
    test_flush_col5();
    test_error();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
